ncl_count_sequencer: RTL and testbench
======================================

Name: ncl_count_sequencer

Overview:
- Clocked controller that drives one dual-rail NCL counter pipeline (two-D digit ring, WIDTH digits) from the synchronous domain.
- Per accepted request it issues one carry-in wavefront pair (DATA then NULL) and acts as the four-phase consumer of the sum and carry-out wavefronts.
- It decodes the count to binary and returns it on a valid-only response port. Used by synchronous test/host logic as the sole owner of the counter's carry-in and completion rails.

Parameters:
- WIDTH, 32, number of counter digits (sum rail pairs).
- SYNC_STAGES, 2, flops on every counter-to-sequencer rail and ack.
- TIMEOUT, 255, maximum cycles spent in any wait state before error.

Ports:
- clk  input  1  clock.
- init  input  1  reset: synchronous, active-high.
- req_valid  input  1  request present.
- req_inc  input  1  1 = increment (carry-in DATA1), 0 = read-only (carry-in DATA0).
- req_ready  output  1  request accepted when req_valid & req_ready.
- resp_valid  output  1  one-cycle pulse, response fields valid.
- resp_count  output  WIDTH  decoded count (rail1 of each digit).
- resp_carry  output  1  decoded carry-out.
- resp_error  output  1  sticky: timeout or illegal rail code.
- resp_mismatch  output  1  sticky: decoded count differs from shadow count.
- cin_dr  output  2  carry-in rails {rail1, rail0}; 00 = NULL.
- cin_ack  input  1  counter stage-0 completion; high = DATA accepted, low = ready for DATA.
- sum_dr  input  2*WIDTH  digit i rails at [2i+1:2i].
- cout_dr  input  2  carry-out rails.
- sum_ack  output  WIDTH  per-digit consume ack; high = request NULL.
- cout_ack  output  1  carry-out consume ack.

Behaviour:
- Reset is synchronous: with init high at a clock edge, on that edge:
  - cin_dr=00, sum_ack=0, cout_ack=0, req_ready=0, resp_valid=0, resp_count=0, resp_carry=0.
  - resp_error=0, resp_mismatch=0, shadow=0, FSMs to IDLE, synchronizers cleared.
- Init mid-operation aborts any wavefront in flight. The NCL counter shares init, so both restart together.
- req_ready=1 only in IDLE with resp_error=0.
- All of cin_ack, sum_dr and cout_dr are sampled only after SYNC_STAGES flops. Rails are monotonic within a phase, so a synchronized "all DATA" or "all NULL" test is safe without further filtering.
- Issue FSM:
  - IDLE: on accept, load cin_dr = req_inc ? 10 : 01 and go to CIN_DATA.
  - CIN_DATA: wait until synced cin_ack=1, then set cin_dr=00 and go to CIN_NULL.
  - CIN_NULL: wait until synced cin_ack=0, then go to ISSUE_DONE.
- Consume FSM (runs concurrently; started by accept):
  - SUM_DATA: wait until every digit and cout show exactly one rail high.
  - On that condition, capture resp_count[i]=sum rail1, resp_carry=cout rail1; set sum_ack and cout_ack all 1; go to SUM_NULL.
  - SUM_NULL: wait until all rails are 00, then drive acks to 0 and go to CONS_DONE.
- Join: when both FSMs are DONE, pulse resp_valid for one cycle and return both FSMs to IDLE. Earliest resp_valid after accept is 2*SYNC_STAGES+3 cycles.
- Shadow count:
  - On accept with req_inc=1: shadow <= shadow+1, modulo 2^WIDTH.
  - At resp_valid: if resp_count != shadow, set resp_mismatch.
  - Expected resp_carry=1 exactly when the increment wrapped shadow from all-ones to 0.
- Illegal code: any synced rail pair equal to 11 sets resp_error. The current response is dropped with no resp_valid.
- Timeout: a per-state cycle counter runs in CIN_DATA, CIN_NULL, SUM_DATA and SUM_NULL. Reaching TIMEOUT sets resp_error.
- On error: drive cin_dr=00 and all acks=0, park both FSMs in IDLE, keep req_ready=0 until init.
- req_valid in a non-IDLE state is ignored; no queuing.

Decomposition:
- Shared package ncl_seq_pkg holds:
  - dual-rail constants: NULL=2'b00, DATA0=2'b01, DATA1=2'b10, ILLEGAL=2'b11;
  - issue and consume state enums.
- One natural sub-module: ncl_dr_completion. It is a synchronizer bank plus reduction giving all_data, all_null and any_illegal for N rail pairs.
- Instantiate it once for sum_dr+cout_dr and once (N=1 ack form) for cin_ack.

Test Plan:
- init for 3 cycles, then req_inc=0 against the NCL counter model (WIDTH=32) -> resp_valid with resp_count=0, resp_carry=0, no error.
- 5 back-to-back req_inc=1 -> resp_count 1,2,3,4,5 in order; resp_mismatch stays 0.
- WIDTH=4, 16 increments -> 15th response count=15, carry=0; 16th response count=0, carry=1; no mismatch.
- Model holds cin_ack low forever after a request -> resp_error=1 exactly TIMEOUT cycles after entering CIN_DATA; cin_dr=00; req_ready stays 0 through further req_valid.
- Model drives digit 7 rails=11 during SUM_DATA -> resp_error=1, no resp_valid for that request.
- Assert init while in SUM_NULL -> next edge shows all outputs at reset values. After init release, req_inc=1 -> resp_count=1.

Source files
------------

// File: rtl/ncl_seq_pkg.sv
// Shared dual-rail codes and FSM state types for the NCL counter sequencer.
package ncl_seq_pkg;

  localparam logic [1:0] NULL    = 2'b00;
  localparam logic [1:0] DATA0   = 2'b01;
  localparam logic [1:0] DATA1   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IssIdle,
    IssCinData,
    IssCinNull,
    IssDone
  } iss_state_e;

  typedef enum logic [1:0] {
    ConsIdle,
    ConsSumData,
    ConsSumNull,
    ConsDone
  } cons_state_e;

endpackage

// File: rtl/ncl_dr_completion.sv
// Synchronizer bank for N dual-rail pairs plus completion reduction on the synced rails.
module ncl_dr_completion
  import ncl_seq_pkg::*;
#(
  parameter int unsigned N           = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           init,
  input  logic [2*N-1:0] dr,
  output logic [2*N-1:0] dr_sync,
  output logic           all_data,
  output logic           all_null,
  output logic           any_illegal
);

  logic [2*N-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (init) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= dr;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign dr_sync = sync_q[SYNC_STAGES-1];

  // Rails are monotonic within a phase, so a plain reduction of the synced value is safe.
  always_comb begin
    all_data    = 1'b1;
    all_null    = 1'b1;
    any_illegal = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      all_data    &= (dr_sync[2*i +: 2] == DATA0) || (dr_sync[2*i +: 2] == DATA1);
      all_null    &= (dr_sync[2*i +: 2] == NULL);
      any_illegal |= (dr_sync[2*i +: 2] == ILLEGAL);
    end
  end

endmodule

// File: rtl/ncl_count_sequencer.sv
// Synchronous controller issuing carry-in wavefronts to an NCL counter ring and consuming
// its sum/carry-out wavefronts, returning the decoded count.
module ncl_count_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               init,
  input  logic               req_valid,
  input  logic               req_inc,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_count,
  output logic               resp_carry,
  output logic               resp_error,
  output logic               resp_mismatch,
  output logic [1:0]         cin_dr,
  input  logic               cin_ack,
  input  logic [2*WIDTH-1:0] sum_dr,
  input  logic [1:0]         cout_dr,
  output logic [WIDTH-1:0]   sum_ack,
  output logic               cout_ack
);

  localparam int unsigned   TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  iss_state_e       iss_q, iss_d;
  cons_state_e      cons_q, cons_d;
  logic [TW-1:0]    iss_tmr_q, iss_tmr_d, cons_tmr_q, cons_tmr_d;
  logic [1:0]       cin_q, cin_d;
  logic             ack_q, ack_d, rdy_q, rdy_d, valid_q, valid_d;
  logic             err_q, err_d, mis_q, mis_d, carry_q, carry_d;
  logic [WIDTH-1:0] count_q, count_d, shadow_q, shadow_d;

  logic [2*WIDTH+1:0] rail_sync;
  logic               rail_data, rail_null, rail_illegal;
  logic [1:0]         ack_sync;
  logic               ack_hi, ack_lo, ack_illegal;
  logic               accept, both_done, iss_wait, cons_wait, iss_to, cons_to, err_set;
  logic               unused_ack_sync;

  ncl_dr_completion #(
    .N          (WIDTH + 1),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rail_cmp (
    .clk        (clk),
    .init       (init),
    .dr         ({cout_dr, sum_dr}),
    .dr_sync    (rail_sync),
    .all_data   (rail_data),
    .all_null   (rail_null),
    .any_illegal(rail_illegal)
  );

  // cin_ack as a single pair {0, ack}: high reads as DATA, low as NULL.
  ncl_dr_completion #(
    .N          (1),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_cmp (
    .clk        (clk),
    .init       (init),
    .dr         ({1'b0, cin_ack}),
    .dr_sync    (ack_sync),
    .all_data   (ack_hi),
    .all_null   (ack_lo),
    .any_illegal(ack_illegal)
  );

  assign unused_ack_sync = ^ack_sync;

  assign accept    = req_valid & rdy_q;
  assign both_done = (iss_q == IssDone) && (cons_q == ConsDone);
  assign iss_wait  = (iss_q == IssCinData) || (iss_q == IssCinNull);
  assign cons_wait = (cons_q == ConsSumData) || (cons_q == ConsSumNull);
  assign iss_to    = iss_wait && (iss_tmr_q == TLAST);
  assign cons_to   = cons_wait && (cons_tmr_q == TLAST);
  assign err_set   = rail_illegal | ack_illegal | iss_to | cons_to;

  always_ff @(posedge clk) begin
    if (init) begin
      iss_q      <= IssIdle;
      cons_q     <= ConsIdle;
      iss_tmr_q  <= '0;
      cons_tmr_q <= '0;
      cin_q      <= NULL;
      ack_q      <= 1'b0;
      rdy_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      shadow_q   <= '0;
    end else begin
      iss_q      <= iss_d;
      cons_q     <= cons_d;
      iss_tmr_q  <= iss_tmr_d;
      cons_tmr_q <= cons_tmr_d;
      cin_q      <= cin_d;
      ack_q      <= ack_d;
      rdy_q      <= rdy_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      shadow_q   <= shadow_d;
    end
  end

  always_comb begin
    iss_d  = iss_q;
    cons_d = cons_q;
    case (iss_q)
      IssIdle:    if (accept) iss_d = IssCinData;
      IssCinData: if (ack_hi) iss_d = IssCinNull;
      IssCinNull: if (ack_lo) iss_d = IssDone;
      IssDone:    if (both_done) iss_d = IssIdle;
      default:    iss_d = IssIdle;
    endcase
    case (cons_q)
      ConsIdle:    if (accept) cons_d = ConsSumData;
      ConsSumData: if (rail_data) cons_d = ConsSumNull;
      ConsSumNull: if (rail_null) cons_d = ConsDone;
      ConsDone:    if (both_done) cons_d = ConsIdle;
      default:     cons_d = ConsIdle;
    endcase
    if (err_q || err_set) begin
      iss_d  = IssIdle;
      cons_d = ConsIdle;
    end
    // Timers restart on every state change and only run while waiting on the counter.
    iss_tmr_d  = (iss_wait && (iss_d == iss_q)) ? iss_tmr_q + 1'b1 : '0;
    cons_tmr_d = (cons_wait && (cons_d == cons_q)) ? cons_tmr_q + 1'b1 : '0;
  end

  always_comb begin
    cin_d    = cin_q;
    ack_d    = ack_q;
    count_d  = count_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    mis_d    = mis_q;
    valid_d  = 1'b0;
    err_d    = err_q | err_set;
    if (accept) begin
      cin_d = req_inc ? DATA1 : DATA0;
      if (req_inc) shadow_d = shadow_q + 1'b1;
    end
    if ((iss_q == IssCinData) && ack_hi) cin_d = NULL;
    if ((cons_q == ConsSumData) && rail_data) begin
      for (int unsigned i = 0; i < WIDTH; i++) count_d[i] = rail_sync[2*i+1];
      carry_d = rail_sync[2*WIDTH+1];
      ack_d   = 1'b1;
    end
    if ((cons_q == ConsSumNull) && rail_null) ack_d = 1'b0;
    if (both_done && !err_d) begin
      valid_d = 1'b1;
      if (count_q != shadow_q) mis_d = 1'b1;
    end
    if (err_d) begin
      cin_d = NULL;
      ack_d = 1'b0;
    end
    rdy_d = (iss_d == IssIdle) && (cons_d == ConsIdle) && !err_d;
  end

  assign req_ready     = rdy_q;
  assign resp_valid    = valid_q;
  assign resp_count    = count_q;
  assign resp_carry    = carry_q;
  assign resp_error    = err_q;
  assign resp_mismatch = mis_q;
  assign cin_dr        = cin_q;
  assign sum_ack       = {WIDTH{ack_q}};
  assign cout_ack      = ack_q;

endmodule

// File: tb/tb_ncl_count_sequencer.sv
// Bench: two sequencers (32 and 4 digits) each driving a behavioural NCL counter with random
// handshake delays; responses are checked against a plain arithmetic count reference.
module tb_ncl_count_sequencer;

  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             init;
  logic [1:0]       req_valid, req_inc, rrdy, rv, rcar, rerr, rmis, cack, coack;
  logic [1:0][1:0]  cin, cout;
  logic [1:0][63:0] sdr;
  logic [1:0][31:0] rcnt, sack;

  int     tests = 0;
  int     fails = 0;
  bit     hold_ack = 1'b0;
  bit     bad7 = 1'b0;
  longint exp_cnt [2];
  int     mph [2];
  logic [31:0] mcnt [2], mnxt [2];

  ncl_count_sequencer #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) u_dut32 (
    .clk(clk), .init(init), .req_valid(req_valid[0]), .req_inc(req_inc[0]),
    .req_ready(rrdy[0]), .resp_valid(rv[0]), .resp_count(rcnt[0]), .resp_carry(rcar[0]),
    .resp_error(rerr[0]), .resp_mismatch(rmis[0]), .cin_dr(cin[0]), .cin_ack(cack[0]),
    .sum_dr(sdr[0]), .cout_dr(cout[0]), .sum_ack(sack[0]), .cout_ack(coack[0])
  );

  ncl_count_sequencer #(.WIDTH(4), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) u_dut4 (
    .clk(clk), .init(init), .req_valid(req_valid[1]), .req_inc(req_inc[1]),
    .req_ready(rrdy[1]), .resp_valid(rv[1]), .resp_count(rcnt[1][3:0]), .resp_carry(rcar[1]),
    .resp_error(rerr[1]), .resp_mismatch(rmis[1]), .cin_dr(cin[1]), .cin_ack(cack[1]),
    .sum_dr(sdr[1][7:0]), .cout_dr(cout[1]), .sum_ack(sack[1][3:0]), .cout_ack(coack[1])
  );

  assign rcnt[1][31:4] = '0;
  assign sack[1][31:4] = '0;

  function automatic logic [31:0] wmask(input int k);
    return (k == 1) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] nxt_val(input logic [31:0] c, input logic inc, input int k);
    return (c + {31'd0, inc}) & wmask(k);
  endfunction

  function automatic logic [63:0] enc(input logic [31:0] v, input int k, input bit bad);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (k == 0 || i < 4) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    if (bad) r[15:14] = 2'b11;
    return r;
  endfunction

  // Counter model: DATA on carry-in yields a sum wavefront and cin_ack; sum_ack returns it to NULL.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (init) begin
        mph[k]  <= 0;
        mcnt[k] <= '0;
        mnxt[k] <= '0;
        cack[k] <= 1'b0;
        sdr[k]  <= '0;
        cout[k] <= 2'b00;
      end else begin
        if (cin[k] == 2'b00 && cack[k] && $urandom_range(0, 1) == 1) cack[k] <= 1'b0;
        case (mph[k])
          0: if (cin[k] != 2'b00 && $urandom_range(0, 1) == 1) begin
            sdr[k]  <= enc(nxt_val(mcnt[k], cin[k] == 2'b10, k), k, bad7 && k == 0);
            cout[k] <= (cin[k] == 2'b10 && mcnt[k] == wmask(k)) ? 2'b10 : 2'b01;
            mnxt[k] <= nxt_val(mcnt[k], cin[k] == 2'b10, k);
            if (!hold_ack) cack[k] <= 1'b1;
            mph[k]  <= 1;
          end
          1: if (sack[k][0] && $urandom_range(0, 1) == 1) begin
            sdr[k]  <= '0;
            cout[k] <= 2'b00;
            mcnt[k] <= mnxt[k];
            mph[k]  <= 2;
          end
          2: if (!sack[k][0] && cin[k] == 2'b00 && !cack[k]) mph[k] <= 0;
          default: mph[k] <= 0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag, input int k);
    check({tag, "_ready"}, rrdy[k], 0);
    check({tag, "_valid"}, rv[k], 0);
    check({tag, "_count"}, rcnt[k], 0);
    check({tag, "_carry"}, rcar[k], 0);
    check({tag, "_error"}, rerr[k], 0);
    check({tag, "_mismatch"}, rmis[k], 0);
    check({tag, "_cin"}, cin[k], 0);
    check({tag, "_sum_ack"}, sack[k], 0);
    check({tag, "_cout_ack"}, coack[k], 0);
  endtask

  task automatic pulse_init();
    @(negedge clk);
    init = 1'b1;
    repeat (2) @(negedge clk);
    init = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
  endtask

  task automatic wait_ready(input int k, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rrdy[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_ready_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic do_req(input int k, input bit inc, input string tag);
    bit     ok, exp_car;
    longint modv;
    modv = longint'(1) << ((k == 1) ? 4 : 32);
    wait_ready(k, tag);
    if (!rrdy[k]) return;
    req_valid[k] = 1'b1;
    req_inc[k]   = inc;
    @(negedge clk);
    req_valid[k] = 1'b0;
    exp_car    = inc && (exp_cnt[k] == modv - 1);
    exp_cnt[k] = (exp_cnt[k] + longint'(inc)) % modv;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (rv[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_resp_seen"}, 64'(ok), 64'd1);
    if (!ok) return;
    check({tag, "_count"}, rcnt[k], 64'(exp_cnt[k]));
    check({tag, "_carry"}, rcar[k], 64'(exp_car));
    check({tag, "_mismatch"}, rmis[k], 0);
    check({tag, "_error"}, rerr[k], 0);
    @(negedge clk);
    check({tag, "_valid_pulse"}, rv[k], 0);
  endtask

  initial begin
    int  first, seen_valid, seen_ready;
    bit  found;
    init       = 1'b1;
    req_valid  = '0;
    req_inc    = '0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset32", 0);
    check_reset("reset4", 1);
    @(negedge clk);
    init = 1'b0;

    do_req(0, 1'b0, "read0");
    for (int i = 0; i < 5; i++) do_req(0, 1'b1, "inc");
    repeat (20) do_req(0, 1'($urandom_range(0, 1)), "rand32");

    for (int i = 0; i < 16; i++) do_req(1, 1'b1, "wrap4");
    repeat (12) do_req(1, 1'($urandom_range(0, 1)), "rand4");

    // Stuck carry-in completion must time out from CIN_DATA.
    pulse_init();
    hold_ack = 1'b1;
    wait_ready(0, "timeout");
    req_valid[0] = 1'b1;
    req_inc[0]   = 1'b1;
    @(posedge clk);
    first      = 0;
    seen_valid = 0;
    seen_ready = 0;
    for (int n = 1; n <= int'(TIMEOUT) + 20; n++) begin
      @(posedge clk);
      #1;
      if (rerr[0] && first == 0) first = n;
      if (rv[0]) seen_valid++;
      if (first != 0 && rrdy[0]) seen_ready++;
    end
    req_valid[0] = 1'b0;
    check("timeout_cycle", 64'(first), 64'(TIMEOUT));
    check("timeout_cin_null", cin[0], 0);
    check("timeout_acks", {sack[0], 31'd0, coack[0]}, 0);
    check("timeout_no_ready", 64'(seen_ready), 0);
    check("timeout_no_valid", 64'(seen_valid), 0);
    hold_ack = 1'b0;

    // Illegal rail code on digit 7 drops the response.
    pulse_init();
    bad7 = 1'b1;
    wait_ready(0, "illegal");
    req_valid[0] = 1'b1;
    req_inc[0]   = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    seen_valid = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rv[0]) seen_valid++;
    end
    check("illegal_error", rerr[0], 1);
    check("illegal_no_valid", 64'(seen_valid), 0);
    check("illegal_ready", rrdy[0], 0);
    check("illegal_cin_null", cin[0], 0);
    bad7 = 1'b0;

    // Init while the consumer is waiting for the NULL wavefront.
    pulse_init();
    wait_ready(0, "midinit");
    req_valid[0] = 1'b1;
    req_inc[0]   = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sack[0][0]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midinit_sum_null_seen", 64'(found), 64'd1);
    init = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midinit", 0);
    @(negedge clk);
    @(negedge clk);
    init = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    do_req(0, 1'b1, "after_init");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
